// File: rtl/latency_meter.sv
// Round-trip latency probe: fires a probe pulse into a delay path and counts
// clk cycles until the rising edge of the returned echo.
module latency_meter #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned TIMEOUT   = 1000,
    parameter int unsigned PULSE_LEN = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    output logic             probe_out,
    input  logic             echo_in,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [CNT_W-1:0] latency
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEAS,
        S_DRAIN
    } state_t;

    localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] PL_LAST = CNT_W'(PULSE_LEN - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_echo_prev;
    logic             r_probe;
    logic             r_busy;
    logic             r_done;
    logic             r_terr;
    logic [CNT_W-1:0] r_lat;
    logic             w_edge;

    assign w_edge = echo_in & ~r_echo_prev;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_echo_prev <= 1'b0;
            r_probe     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_terr      <= 1'b0;
            r_lat       <= '0;
        end else begin
            r_echo_prev <= echo_in;
            r_done      <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    // A high echo means the path is not quiet; refuse to start.
                    if (start && !echo_in) begin
                        r_state <= S_MEAS;
                        r_cnt   <= '0;
                        r_probe <= 1'b1;
                        r_busy  <= 1'b1;
                        r_terr  <= 1'b0;
                    end
                end
                S_MEAS: begin
                    r_cnt   <= r_cnt + 1'b1;
                    // Probe stays high through cycle PULSE_LEN-1, then latches low.
                    r_probe <= r_probe && (r_cnt != PL_LAST);
                    if (w_edge) begin
                        r_lat   <= r_cnt;
                        r_done  <= 1'b1;
                        r_probe <= 1'b0;
                        r_state <= S_DRAIN;
                    end else if (r_cnt == TO_CNT) begin
                        r_lat   <= '1;
                        r_terr  <= 1'b1;
                        r_done  <= 1'b1;
                        r_probe <= 1'b0;
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_probe <= 1'b0;
                    if (!echo_in) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_probe <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign probe_out   = r_probe;
    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout_err = r_terr;
    assign latency     = r_lat;

endmodule

// File: tb/tb_latency_meter.sv
// Directed bench for latency_meter: configurable delay path around one DUT,
// a fixed 2-stage chain around a second DUT with a 4-cycle probe pulse.
module tb_latency_meter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        start_a, start_b;
    logic        probe_a, busy_a, done_a, terr_a, echo_a;
    logic        probe_b, busy_b, done_b, terr_b, echo_b;
    logic [15:0] lat_a, lat_b;
    logic [15:0] sr_a = '0;
    logic [15:0] sr_b = '0;
    int          mode_a;
    int          tap_a;
    int          checks   = 0;
    int          failures = 0;

    latency_meter #(.CNT_W(16), .TIMEOUT(20), .PULSE_LEN(1)) dut_a (
        .clk(clk), .resetn(resetn), .start(start_a), .probe_out(probe_a),
        .echo_in(echo_a), .busy(busy_a), .done(done_a),
        .timeout_err(terr_a), .latency(lat_a)
    );

    latency_meter #(.CNT_W(16), .TIMEOUT(20), .PULSE_LEN(4)) dut_b (
        .clk(clk), .resetn(resetn), .start(start_b), .probe_out(probe_b),
        .echo_in(echo_b), .busy(busy_b), .done(done_b),
        .timeout_err(terr_b), .latency(lat_b)
    );

    // Delay path models: sr[n] is probe_out delayed by n+1 flops.
    always @(posedge clk) begin
        sr_a <= {sr_a[14:0], probe_a};
        sr_b <= {sr_b[14:0], probe_b};
    end

    // mode_a: 0 = tied low, 1 = tied high, 2 = direct wire, 3 = chain of tap_a flops
    always_comb begin
        case (mode_a)
            0:       echo_a = 1'b0;
            1:       echo_a = 1'b1;
            2:       echo_a = probe_a;
            default: echo_a = sr_a[tap_a-1];
        endcase
    end
    assign echo_b = sr_b[1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts a measurement on dut_a and checks C0, done cycle index, result and drain.
    task automatic run_a(input string tag, input int exp_idx,
                         input logic [15:0] exp_lat, input logic exp_terr);
        int idx;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        chk({tag, "_c0_probe"}, 32'(probe_a), 32'd1);
        chk({tag, "_c0_busy"},  32'(busy_a),  32'd1);
        chk({tag, "_c0_terr"},  32'(terr_a),  32'd0);
        idx = 0;
        while (!done_a && idx < 60) begin
            @(negedge clk);
            idx++;
        end
        chk({tag, "_done_cycle"}, 32'(idx), 32'(exp_idx));
        chk({tag, "_latency"},    32'(lat_a), 32'(exp_lat));
        chk({tag, "_terr"},       32'(terr_a), 32'(exp_terr));
        idx = 0;
        while (busy_a && idx < 60) begin
            @(negedge clk);
            idx++;
        end
        chk({tag, "_busy_clear"}, 32'(busy_a), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int ndone;
        resetn  = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        mode_a  = 0;
        tap_a   = 8;
        repeat (2) @(negedge clk);
        chk("rst_probe", 32'(probe_a), 32'd0);
        chk("rst_busy",  32'(busy_a),  32'd0);
        chk("rst_done",  32'(done_a),  32'd0);
        chk("rst_terr",  32'(terr_a),  32'd0);
        chk("rst_lat",   32'(lat_a),   32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // 8-stage chain
        mode_a = 3; tap_a = 8;
        run_a("chain8", 9, 16'd8, 1'b0);

        // Zero-delay path
        mode_a = 2;
        run_a("wire", 1, 16'd0, 1'b0);

        // No echo: timeout at C20, error held until the next accepted start
        mode_a = 0;
        run_a("timeout", 21, 16'hFFFF, 1'b1);
        chk("timeout_held", 32'(terr_a), 32'd1);
        mode_a = 3; tap_a = 8;
        run_a("after_to", 9, 16'd8, 1'b0);

        // Reset in C3 of an 8-stage measurement
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("midrst_probe", 32'(probe_a), 32'd0);
        chk("midrst_busy",  32'(busy_a),  32'd0);
        chk("midrst_done",  32'(done_a),  32'd0);
        chk("midrst_lat",   32'(lat_a),   32'd0);
        resetn = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done_a) ndone++;
        end
        chk("midrst_no_done", 32'(ndone), 32'd0);
        run_a("post_rst", 9, 16'd8, 1'b0);

        // Echo stuck high: start ignored
        mode_a = 1;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        chk("echohi_busy",  32'(busy_a),  32'd0);
        chk("echohi_probe", 32'(probe_a), 32'd0);
        @(negedge clk);
        chk("echohi_busy2", 32'(busy_a),  32'd0);
        mode_a = 3;

        // PULSE_LEN=4 into a 2-stage chain; starts while busy are dropped
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        chk("p4_c0_probe", 32'(probe_b), 32'd1);
        chk("p4_c0_busy",  32'(busy_b),  32'd1);
        @(negedge clk) start_b = 1'b1;
        chk("p4_c1_probe", 32'(probe_b), 32'd1);
        @(negedge clk);
        chk("p4_c2_probe", 32'(probe_b), 32'd1);
        chk("p4_c2_done",  32'(done_b),  32'd0);
        @(negedge clk);
        chk("p4_c3_done",  32'(done_b),  32'd1);
        chk("p4_c3_lat",   32'(lat_b),   32'd2);
        chk("p4_c3_probe", 32'(probe_b), 32'd0);
        chk("p4_c3_busy",  32'(busy_b),  32'd1);
        @(negedge clk);
        chk("p4_c4_busy",  32'(busy_b),  32'd1);
        chk("p4_c4_done",  32'(done_b),  32'd0);
        @(negedge clk);
        chk("p4_c5_busy",  32'(busy_b),  32'd1);
        @(negedge clk);
        chk("p4_c6_busy",  32'(busy_b),  32'd0);
        chk("p4_c6_probe", 32'(probe_b), 32'd0);
        start_b = 1'b0;
        @(negedge clk);
        chk("p4_c7_busy",  32'(busy_b),  32'd0);
        chk("p4_c7_probe", 32'(probe_b), 32'd0);
        chk("p4_terr",     32'(terr_b),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
